// File: rtl/boot_rom_copier.sv
// boot_rom_copier: copies a block of 32-bit words from the on-chip boot ROM
// (1-cycle read latency, no waitrequest) into a destination Avalon-MM slave
// through a 2-entry FIFO, sustaining 1 word/cycle when the slave is not stalling.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_start                 one-cycle request, sampled only in IDLE
//   i_src_word_addr         first ROM word address
//   i_dst_byte_addr         first destination byte address (bits [1:0] ignored)
//   i_num_words             number of words to copy (0 is legal)
//   o_busy / o_done         transfer in progress / one-cycle completion pulse
//   o_checksum              sum of copied words (0 unless the macro is defined)
//   o_rom_*, i_rom_readdata ROM read port
//   o_dst_*, i_dst_waitrequest destination write master
//
// Optional feature: define BOOT_ROM_COPIER_CHECKSUM_EN to build the checksum adder.

module boot_rom_copier #(
    parameter int unsigned ROM_AW = 11,
    parameter int unsigned LEN_W  = 12
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ROM_AW-1:0] i_src_word_addr,
    input  logic [31:0]       i_dst_byte_addr,
    input  logic [LEN_W-1:0]  i_num_words,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_checksum,
    output logic [ROM_AW-1:0] o_rom_address,
    output logic              o_rom_chipselect,
    input  logic [31:0]       i_rom_readdata,
    output logic [31:0]       o_dst_address,
    output logic              o_dst_write,
    output logic [31:0]       o_dst_writedata,
    output logic [3:0]        o_dst_byteenable,
    input  logic              i_dst_waitrequest
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ROM_AW-1:0]   r_src;
    logic [31:0]         r_dst;
    logic [LEN_W-1:0]    r_reads_left;
    logic [LEN_W-1:0]    r_writes_left;
    logic                r_inflight;
    logic [31:0]         r_fifo [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_fifo_count;

    logic                w_start_ok;
    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic                w_last_pop;
    logic [2:0]          w_occ;
    logic [2:0]          w_limit;

    assign w_start_ok = (r_state == S_IDLE) && i_start;
    assign w_pop      = o_dst_write && !i_dst_waitrequest;
    assign w_push     = r_inflight;
    assign w_last_pop = w_pop && (r_writes_left == LEN_W'(1));

    // Credit rule: a slot freed by this cycle's pop can be refilled by this cycle's read.
    assign w_occ   = 3'(r_fifo_count) + 3'(r_inflight);
    assign w_limit = 3'd2 + 3'(w_pop);
    assign w_issue = (r_state == S_RUN) && (r_reads_left != '0) && (w_occ < w_limit);

    assign o_rom_address    = r_src;
    assign o_dst_address    = r_dst;
    assign o_dst_write      = (r_fifo_count != 2'd0);
    assign o_dst_writedata  = r_fifo[r_rd_ptr];
    assign o_dst_byteenable = 4'hF;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_num_words == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_pop) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_busy           = 1'b0;
        o_done           = 1'b0;
        o_rom_chipselect = 1'b0;
        case (r_state)
            S_RUN: begin
                o_busy           = 1'b1;
                o_rom_chipselect = w_issue;
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    // Address/count tracking and the 2-entry FIFO
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_src         <= '0;
            r_dst         <= '0;
            r_reads_left  <= '0;
            r_writes_left <= '0;
            r_inflight    <= 1'b0;
            r_fifo[0]     <= '0;
            r_fifo[1]     <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_fifo_count  <= 2'd0;
        end else if (w_start_ok) begin
            r_src         <= i_src_word_addr;
            r_dst         <= {i_dst_byte_addr[31:2], 2'b00};
            r_reads_left  <= i_num_words;
            r_writes_left <= i_num_words;
            r_inflight    <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_fifo_count  <= 2'd0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_src        <= r_src + ROM_AW'(1);
                r_reads_left <= r_reads_left - LEN_W'(1);
            end
            if (w_push) begin
                r_fifo[r_wr_ptr] <= i_rom_readdata;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr      <= ~r_rd_ptr;
                r_dst         <= r_dst + 32'd4;
                r_writes_left <= r_writes_left - LEN_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 2'd1;
                2'b01:   r_fifo_count <= r_fifo_count - 2'd1;
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

`ifdef BOOT_ROM_COPIER_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Running sum of accepted words; holds after completion
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + o_dst_writedata;
        end
    end

    assign o_checksum = r_checksum;
`else
    assign o_checksum = 32'h0;
`endif

endmodule

// File: tb/tb_boot_rom_copier.sv
// Bench for boot_rom_copier: ROM and destination-slave models, a directed
// vector table, a reset-abort sequence and randomized copies with stalls.
module tb_boot_rom_copier;

    localparam int unsigned ROM_AW = 11;
    localparam int unsigned LEN_W  = 12;
    localparam int          ROM_N  = 2048;
    localparam int          MAXW   = 64;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_start;
    logic [ROM_AW-1:0] i_src_word_addr;
    logic [31:0]       i_dst_byte_addr;
    logic [LEN_W-1:0]  i_num_words;
    logic              o_busy;
    logic              o_done;
    logic [31:0]       o_checksum;
    logic [ROM_AW-1:0] o_rom_address;
    logic              o_rom_chipselect;
    logic [31:0]       i_rom_readdata;
    logic [31:0]       o_dst_address;
    logic              o_dst_write;
    logic [31:0]       o_dst_writedata;
    logic [3:0]        o_dst_byteenable;
    logic              i_dst_waitrequest;

    boot_rom_copier #(.ROM_AW(ROM_AW), .LEN_W(LEN_W)) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_start           (i_start),
        .i_src_word_addr   (i_src_word_addr),
        .i_dst_byte_addr   (i_dst_byte_addr),
        .i_num_words       (i_num_words),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_checksum        (o_checksum),
        .o_rom_address     (o_rom_address),
        .o_rom_chipselect  (o_rom_chipselect),
        .i_rom_readdata    (i_rom_readdata),
        .o_dst_address     (o_dst_address),
        .o_dst_write       (o_dst_write),
        .o_dst_writedata   (o_dst_writedata),
        .o_dst_byteenable  (o_dst_byteenable),
        .i_dst_waitrequest (i_dst_waitrequest)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct {
        int          src;
        logic [31:0] dst;
        int          n;
        int          st_idx;
        int          st_len;
        bit          poke;
        int          exp_done;
    } vec_t;

    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc = 0;
    logic [31:0]       rom [ROM_N];
    logic [31:0]       exp_addr [MAXW];
    logic [31:0]       exp_data [MAXW];
    int                stall_a [MAXW];
    int                exp_src = 0;
    int                exp_wr_n = 0;
    int                exp_rd_n = 0;
    int                wr_idx = 0;
    int                rd_idx = 0;
    int                given = 0;
    int                done_cyc = -1;
    bit                noise = 1'b0;
    bit                rd_pend = 1'b0;
    logic [ROM_AW-1:0] rd_pend_addr = '0;
    vec_t              tab [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: ROM and slave models act at the falling edge, outputs sampled 1ns later
    task automatic step();
        @(negedge i_clk);
        cyc++;
        i_rom_readdata = rd_pend ? rom[rd_pend_addr] : $urandom();
        if (o_dst_write) begin
            if (wr_idx >= exp_wr_n) begin
                check("wr_extra", 32'(wr_idx + 1), 32'(exp_wr_n));
                i_dst_waitrequest = 1'b0;
            end else begin
                check("wr_addr", o_dst_address, exp_addr[wr_idx]);
                check("wr_data", o_dst_writedata, exp_data[wr_idx]);
                if (given < stall_a[wr_idx]) begin
                    i_dst_waitrequest = 1'b1;
                    given++;
                end else begin
                    i_dst_waitrequest = 1'b0;
                    wr_idx++;
                    given = 0;
                end
            end
        end else begin
            i_dst_waitrequest = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        #1;
        rd_pend      = o_rom_chipselect;
        rd_pend_addr = o_rom_address;
        if (o_rom_chipselect) begin
            if (rd_idx >= exp_rd_n) begin
                check("rd_extra", 32'(rd_idx + 1), 32'(exp_rd_n));
            end else begin
                check("rd_addr", 32'(o_rom_address), 32'((exp_src + rd_idx) % ROM_N));
            end
            rd_idx++;
        end
        if (o_done && done_cyc < 0) done_cyc = cyc;
    endtask

    task automatic set_model(input int src, input logic [31:0] dst, input int n, output logic [31:0] ck);
        logic [31:0] sum;
        sum = '0;
        exp_src  = src;
        exp_wr_n = n;
        exp_rd_n = n;
        wr_idx   = 0;
        rd_idx   = 0;
        given    = 0;
        done_cyc = -1;
        for (int i = 0; i < n; i++) begin
            exp_addr[i] = {dst[31:2], 2'b00} + 32'(4 * i);
            exp_data[i] = rom[(src + i) % ROM_N];
            sum = sum + exp_data[i];
        end
`ifdef BOOT_ROM_COPIER_CHECKSUM_EN
        ck = sum;
`else
        ck = 32'h0;
`endif
    endtask

    task automatic run_copy(input int src, input logic [31:0] dst, input int n,
                            input int exp_done, input bit poke);
        logic [31:0] exp_ck;
        set_model(src, dst, n, exp_ck);
        step();
        cyc             = 0;
        i_start         = 1'b1;
        i_src_word_addr = ROM_AW'(src);
        i_dst_byte_addr = dst;
        i_num_words     = LEN_W'(n);
        step();
        i_start = 1'b0;
        if (n > 0) check("busy_c1", 32'(o_busy), 32'd1);
        while (done_cyc < 0 && cyc < exp_done + 10) begin
            if (poke && cyc == 2) begin
                i_start         = 1'b1;
                i_src_word_addr = ROM_AW'(src + 77);
                i_dst_byte_addr = dst ^ 32'h0000_8000;
                i_num_words     = LEN_W'(5);
            end else begin
                i_start = 1'b0;
            end
            step();
        end
        i_start = 1'b0;
        check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("busy_at_done", 32'(o_busy), 32'd0);
        check("n_writes", 32'(wr_idx), 32'(n));
        check("n_reads", 32'(rd_idx), 32'(n));
        check("checksum", o_checksum, exp_ck);
        step();
        check("done_len", 32'(o_done), 32'd0);
        check("busy_after", 32'(o_busy), 32'd0);
        check("checksum_hold", o_checksum, exp_ck);
    endtask

    initial begin
        logic [31:0] ck;
        int          n;
        int          tot;

        i_reset           = 1'b1;
        i_start           = 1'b0;
        i_src_word_addr   = '0;
        i_dst_byte_addr   = '0;
        i_num_words       = '0;
        i_rom_readdata    = '0;
        i_dst_waitrequest = 1'b0;
        for (int i = 0; i < ROM_N; i++) rom[i] = $urandom();
        for (int i = 0; i < 4; i++) rom[i] = 32'(i + 1);
        for (int i = 0; i < MAXW; i++) stall_a[i] = 0;

        step();
        step();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_checksum", o_checksum, 32'd0);
        check("rst_cs", 32'(o_rom_chipselect), 32'd0);
        check("rst_rom_addr", 32'(o_rom_address), 32'd0);
        check("rst_dst_write", 32'(o_dst_write), 32'd0);
        check("rst_dst_addr", o_dst_address, 32'd0);
        check("rst_wdata", o_dst_writedata, 32'd0);
        check("rst_be", 32'(o_dst_byteenable), 32'hF);
        i_reset = 1'b0;
        step();

        // src, dst, n, stall index, stall length, start-while-busy, expected done cycle
        tab[0] = '{0,    32'h0000_1000, 4, -1, 0, 1'b0, 7};
        tab[1] = '{0,    32'h0000_1000, 4,  1, 3, 1'b0, 10};
        tab[2] = '{2046, 32'h0000_2000, 4, -1, 0, 1'b0, 7};
        tab[3] = '{5,    32'h0000_3000, 0, -1, 0, 1'b0, 1};
        tab[4] = '{100,  32'hFFFF_FFFB, 4, -1, 0, 1'b0, 7};
        tab[5] = '{7,    32'h0000_0040, 1,  0, 2, 1'b0, 6};
        tab[6] = '{0,    32'h0000_1000, 4, -1, 0, 1'b1, 7};
        tab[7] = '{10,   32'h0000_0500, 3,  0, 2, 1'b0, 8};
        noise = 1'b0;
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < MAXW; i++) stall_a[i] = 0;
            if (tab[v].st_idx >= 0) stall_a[tab[v].st_idx] = tab[v].st_len;
            run_copy(tab[v].src, tab[v].dst, tab[v].n, tab[v].exp_done, tab[v].poke);
        end

        // Reset in cycle 4 of an 8-word copy, then a clean copy
        for (int i = 0; i < MAXW; i++) stall_a[i] = 0;
        set_model(0, 32'h0000_1000, 8, ck);
        step();
        cyc             = 0;
        i_start         = 1'b1;
        i_src_word_addr = '0;
        i_dst_byte_addr = 32'h0000_1000;
        i_num_words     = LEN_W'(8);
        step();
        i_start = 1'b0;
        step();
        step();
        step();
        i_reset  = 1'b1;
        exp_wr_n = wr_idx;
        exp_rd_n = rd_idx;
        step();
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_write", 32'(o_dst_write), 32'd0);
        check("abort_cs", 32'(o_rom_chipselect), 32'd0);
        check("abort_dst_addr", o_dst_address, 32'd0);
        check("abort_checksum", o_checksum, 32'd0);
        i_reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("abort_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
        run_copy(0, 32'h0000_1000, 8, 11, 1'b0);

        // Randomized copies with random stalls and idle-time waitrequest noise
        noise = 1'b1;
        for (int r = 0; r < 20; r++) begin
            n   = $urandom_range(0, 24);
            tot = 0;
            for (int i = 0; i < MAXW; i++) stall_a[i] = 0;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) stall_a[i] = $urandom_range(1, 4);
                tot += stall_a[i];
            end
            run_copy($urandom_range(0, ROM_N - 1), $urandom(), n,
                     (n == 0) ? 1 : n + 3 + tot, (r % 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
